// File: rtl/acq_sweep_ctrl_if.sv
// ---------------------------------------------------------------------------
// acq_sweep_ctrl_if
// Bundle between the SPI command decoder / correlator channel side and the
// acquisition sweep controller.
//
//   Command side   : start, abort (1-cycle pulses), dop_center[11:0], threshold[15:0]
//   Correlator in  : corr_valid, corr_power[15:0]
//   Channel config : satset[4:0], dopset[11:0]
//   Status         : busy, done, found, found_prn[4:0], found_dop[11:0], best_power[15:0]
//
// modport master : the environment (decoder + correlator) that drives commands
//                  and power samples and observes configuration/status.
// modport slave  : the sweep controller itself.
// ---------------------------------------------------------------------------
interface acq_sweep_ctrl_if;
    logic        start;
    logic        abort;
    logic [11:0] dop_center;
    logic [15:0] threshold;
    logic        corr_valid;
    logic [15:0] corr_power;
    logic [4:0]  satset;
    logic [11:0] dopset;
    logic        busy;
    logic        done;
    logic        found;
    logic [4:0]  found_prn;
    logic [11:0] found_dop;
    logic [15:0] best_power;

    modport master (
        output start, abort, dop_center, threshold, corr_valid, corr_power,
        input  satset, dopset, busy, done, found, found_prn, found_dop, best_power
    );

    modport slave (
        input  start, abort, dop_center, threshold, corr_valid, corr_power,
        output satset, dopset, busy, done, found, found_prn, found_dop, best_power
    );
endinterface

// File: rtl/acq_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// acq_sweep_ctrl
// Autonomous acquisition sweep for one GPS correlator channel. Steps PRN
// (outer loop) and Doppler bin (inner loop), waits for the channel to settle
// after each retune, tracks the peak correlation power over a dwell window
// and stops at the first bin whose peak reaches the threshold. Otherwise the
// whole PRN x Doppler grid is swept and the strongest bin is reported.
//
// Ports
//   clk    : system clock
//   rst_n  : synchronous reset, active low (sampled on posedge clk)
//   bus    : acq_sweep_ctrl_if.slave
//              start/abort pulses, dop_center, threshold, corr_valid/corr_power in;
//              satset/dopset channel configuration and busy/done/found/found_prn/
//              found_dop/best_power status out (all registered).
// ---------------------------------------------------------------------------
module acq_sweep_ctrl #(
    parameter int SETTLE_CYC = 2047,
    parameter int DWELL_CYC  = 16368,
    parameter int DOP_BINS   = 21,
    parameter int DOP_STEP   = 4,
    parameter int PRN_CNT    = 32
) (
    input logic            clk,
    input logic            rst_n,
    acq_sweep_ctrl_if.slave bus
);

    localparam int CNT_MAX   = (SETTLE_CYC > DWELL_CYC) ? SETTLE_CYC : DWELL_CYC;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);
    localparam int HALF_BINS = (DOP_BINS - 1) / 2;

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST  = CNT_W'(DWELL_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO    = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [7:0]       BIN_LAST    = 8'(DOP_BINS - 1);
    localparam logic [4:0]       PRN_LAST    = 5'(PRN_CNT - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_DWELL  = 3'd2,
        ST_EVAL   = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Doppler code of bin k: centre plus signed bin offset, wrapping modulo 4096.
    function automatic logic [11:0] bin_dopset(input logic [11:0] center, input logic [7:0] k);
        int offs;
        int sum;
        offs = (int'(k) - HALF_BINS) * DOP_STEP;
        sum  = int'(center) + offs;
        return sum[11:0];
    endfunction

    state_t            state_r, state_nxt_s;
    logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
    logic [7:0]        k_r, k_nxt_s;
    logic [4:0]        satset_r, satset_nxt_s;
    logic [11:0]       dopset_r, dopset_nxt_s;
    logic [11:0]       center_r, center_nxt_s;
    logic [15:0]       thr_r, thr_nxt_s;
    logic [15:0]       peak_r, peak_nxt_s;
    logic              busy_r, busy_nxt_s;
    logic              done_r, done_nxt_s;
    logic              found_r, found_nxt_s;
    logic [4:0]        fprn_r, fprn_nxt_s;
    logic [11:0]       fdop_r, fdop_nxt_s;
    logic [15:0]       best_r, best_nxt_s;

    logic              settle_end_s;
    logic              dwell_end_s;
    logic              last_bin_s;
    logic              detect_s;
    logic              better_s;
    logic              bin_wrap_s;
    logic [7:0]        adv_k_s;
    logic [4:0]        adv_prn_s;

    assign settle_end_s = (cnt_r == SETTLE_LAST);
    assign dwell_end_s  = (cnt_r == DWELL_LAST);
    assign last_bin_s   = (satset_r == PRN_LAST) && (k_r == BIN_LAST);
    assign detect_s     = (peak_r >= thr_r);
    assign better_s     = (peak_r > best_r);
    assign bin_wrap_s   = (k_r == BIN_LAST);
    assign adv_k_s      = bin_wrap_s ? 8'd0 : (k_r + 8'd1);
    assign adv_prn_s    = bin_wrap_s ? (satset_r + 5'd1) : satset_r;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; abort takes priority in every active state.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start && !bus.abort) begin
                    state_nxt_s = ST_SETTLE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (bus.abort) begin
                    state_nxt_s = ST_IDLE;
                end else if (settle_end_s) begin
                    state_nxt_s = ST_DWELL;
                end else begin
                    state_nxt_s = ST_SETTLE;
                end
            end
            ST_DWELL: begin
                if (bus.abort) begin
                    state_nxt_s = ST_IDLE;
                end else if (dwell_end_s) begin
                    state_nxt_s = ST_EVAL;
                end else begin
                    state_nxt_s = ST_DWELL;
                end
            end
            ST_EVAL: begin
                if (bus.abort) begin
                    state_nxt_s = ST_IDLE;
                end else if (detect_s || last_bin_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_SETTLE;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Output / datapath next values; everything holds unless the state says otherwise.
    always_comb begin
        cnt_nxt_s    = cnt_r;
        k_nxt_s      = k_r;
        satset_nxt_s = satset_r;
        dopset_nxt_s = dopset_r;
        center_nxt_s = center_r;
        thr_nxt_s    = thr_r;
        peak_nxt_s   = peak_r;
        busy_nxt_s   = busy_r;
        done_nxt_s   = 1'b0;
        found_nxt_s  = found_r;
        fprn_nxt_s   = fprn_r;
        fdop_nxt_s   = fdop_r;
        best_nxt_s   = best_r;

        case (state_r)
            ST_IDLE: begin
                if (state_nxt_s == ST_SETTLE) begin
                    // Sweep launch: centre and threshold are captured only here.
                    cnt_nxt_s    = CNT_ZERO;
                    k_nxt_s      = 8'd0;
                    satset_nxt_s = 5'd0;
                    dopset_nxt_s = bin_dopset(bus.dop_center, 8'd0);
                    center_nxt_s = bus.dop_center;
                    thr_nxt_s    = bus.threshold;
                    peak_nxt_s   = 16'd0;
                    busy_nxt_s   = 1'b1;
                    found_nxt_s  = 1'b0;
                    fprn_nxt_s   = 5'd0;
                    fdop_nxt_s   = 12'd0;
                    best_nxt_s   = 16'd0;
                end else begin
                    busy_nxt_s   = 1'b0;
                end
            end
            ST_SETTLE: begin
                if (state_nxt_s == ST_SETTLE) begin
                    cnt_nxt_s  = cnt_r + CNT_ONE;
                end else begin
                    // Leaving SETTLE either enters DWELL (fresh peak) or aborts.
                    cnt_nxt_s  = CNT_ZERO;
                    peak_nxt_s = 16'd0;
                    busy_nxt_s = (state_nxt_s == ST_DWELL);
                end
            end
            ST_DWELL: begin
                // The final dwell cycle still contributes a sample.
                if (bus.corr_valid && (bus.corr_power > peak_r)) begin
                    peak_nxt_s = bus.corr_power;
                end else begin
                    peak_nxt_s = peak_r;
                end
                if (state_nxt_s == ST_DWELL) begin
                    cnt_nxt_s  = cnt_r + CNT_ONE;
                end else begin
                    cnt_nxt_s  = CNT_ZERO;
                    busy_nxt_s = (state_nxt_s == ST_EVAL);
                end
            end
            ST_EVAL: begin
                if (bus.abort) begin
                    busy_nxt_s = 1'b0;
                end else begin
                    // A detecting bin is always reported, even when it ties the best.
                    if (detect_s || better_s) begin
                        best_nxt_s = peak_r;
                        fprn_nxt_s = satset_r;
                        fdop_nxt_s = dopset_r;
                    end else begin
                        best_nxt_s = best_r;
                    end
                    if (detect_s) begin
                        found_nxt_s = 1'b1;
                    end else begin
                        found_nxt_s = found_r;
                    end
                    if (state_nxt_s == ST_DONE) begin
                        busy_nxt_s = 1'b0;
                        done_nxt_s = 1'b1;
                    end else begin
                        k_nxt_s      = adv_k_s;
                        satset_nxt_s = adv_prn_s;
                        dopset_nxt_s = bin_dopset(center_r, adv_k_s);
                    end
                end
            end
            ST_DONE: begin
                busy_nxt_s = 1'b0;
            end
            default: begin
                busy_nxt_s = 1'b0;
            end
        endcase
    end

    // Datapath and status registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r    <= CNT_ZERO;
            k_r      <= 8'd0;
            satset_r <= 5'd0;
            dopset_r <= 12'd0;
            center_r <= 12'd0;
            thr_r    <= 16'd0;
            peak_r   <= 16'd0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            found_r  <= 1'b0;
            fprn_r   <= 5'd0;
            fdop_r   <= 12'd0;
            best_r   <= 16'd0;
        end else begin
            cnt_r    <= cnt_nxt_s;
            k_r      <= k_nxt_s;
            satset_r <= satset_nxt_s;
            dopset_r <= dopset_nxt_s;
            center_r <= center_nxt_s;
            thr_r    <= thr_nxt_s;
            peak_r   <= peak_nxt_s;
            busy_r   <= busy_nxt_s;
            done_r   <= done_nxt_s;
            found_r  <= found_nxt_s;
            fprn_r   <= fprn_nxt_s;
            fdop_r   <= fdop_nxt_s;
            best_r   <= best_nxt_s;
        end
    end

    assign bus.satset     = satset_r;
    assign bus.dopset     = dopset_r;
    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.found      = found_r;
    assign bus.found_prn  = fprn_r;
    assign bus.found_dop  = fdop_r;
    assign bus.best_power = best_r;

endmodule

// File: tb/tb_acq_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// tb_acq_sweep_ctrl
// Directed + randomized bench for acq_sweep_ctrl with small timing parameters.
// Each sweep's correlator stimulus is tabulated per (bin, cycle-within-bin)
// before the sweep; the expected outcome is derived from that table by a
// plain scan over bins (max over dwell samples, strict-greater best, first
// bin at/above threshold stops the sweep).
// ---------------------------------------------------------------------------
module tb_acq_sweep_ctrl;

    localparam int S    = 2;
    localparam int D    = 8;
    localparam int B    = 3;
    localparam int STEP = 4;
    localparam int P    = 4;
    localparam int BT   = S + D + 1;
    localparam int NB   = B * P;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    acq_sweep_ctrl_if ifc ();

    acq_sweep_ctrl #(
        .SETTLE_CYC (S),
        .DWELL_CYC  (D),
        .DOP_BINS   (B),
        .DOP_STEP   (STEP),
        .PRN_CNT    (P)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] pw [NB][BT];
    logic        vl [NB][BT];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] ref_dop(input logic [11:0] c, input int k);
        int v;
        v = int'(c) + (k - (B - 1) / 2) * STEP;
        return 12'(v);
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},  32'(ifc.busy),       32'd0);
        chk({tag, "_done"},  32'(ifc.done),       32'd0);
        chk({tag, "_found"}, 32'(ifc.found),      32'd0);
        chk({tag, "_sat"},   32'(ifc.satset),     32'd0);
        chk({tag, "_dop"},   32'(ifc.dopset),     32'd0);
        chk({tag, "_fprn"},  32'(ifc.found_prn),  32'd0);
        chk({tag, "_fdop"},  32'(ifc.found_dop),  32'd0);
        chk({tag, "_best"},  32'(ifc.best_power), 32'd0);
    endtask

    // mode 0: 600 only in PRN2/k2, others below 500; 1: power=k*10+prn;
    // 2: 900 valid only during settle; 3: random dwell, 0xFFFF garbage outside dwell
    task automatic fill(input int mode);
        for (int b = 0; b < NB; b++) begin
            for (int p = 0; p < BT; p++) begin
                case (mode)
                    0: begin
                        vl[b][p] = 1'b1;
                        pw[b][p] = (b == 2 * B + 2) ? 16'd600 : 16'($urandom_range(0, 499));
                    end
                    1: begin
                        vl[b][p] = 1'b1;
                        pw[b][p] = 16'((b % B) * 10 + (b / B));
                    end
                    2: begin
                        vl[b][p] = (p < S);
                        pw[b][p] = (p < S) ? 16'd900 : 16'd0;
                    end
                    default: begin
                        if (p >= S && p < S + D) begin
                            vl[b][p] = 1'($urandom_range(0, 1));
                            pw[b][p] = 16'($urandom_range(0, 999));
                        end else begin
                            vl[b][p] = 1'b1;
                            pw[b][p] = 16'hFFFF;
                        end
                    end
                endcase
            end
        end
    endtask

    task automatic run_sweep(input string tag, input logic [11:0] center, input logic [15:0] thr,
                             input int abort_at, input int restart_at);
        int nb, lim, last_busy, done_t, end_t, hold_bin, bx, bb, pp;
        int efound, eprn, edop, ebest, peak;

        // Reference outcome from the stimulus table.
        nb = NB;
        lim = (abort_at > 0) ? (abort_at - 1) / BT : NB;
        efound = 0; eprn = 0; edop = 0; ebest = 0;
        for (int b = 0; b < NB; b++) begin
            peak = 0;
            for (int p = S; p < S + D; p++) begin
                if (vl[b][p] && int'(pw[b][p]) > peak) peak = int'(pw[b][p]);
            end
            if (b < lim) begin
                if (peak > ebest || peak >= int'(thr)) begin
                    ebest = peak;
                    eprn = b / B;
                    edop = int'(ref_dop(center, b % B));
                end
                if (peak >= int'(thr)) efound = 1;
            end
            if (peak >= int'(thr)) begin
                nb = b + 1;
                break;
            end
        end

        last_busy = (abort_at > 0) ? abort_at : BT * nb;
        done_t    = (abort_at > 0) ? -1 : BT * nb + 1;
        end_t     = last_busy + 3;
        hold_bin  = (last_busy - 1) / BT;

        @(posedge clk); #1;
        ifc.start = 1'b1;
        ifc.abort = 1'b0;
        ifc.dop_center = center;
        ifc.threshold = thr;
        ifc.corr_valid = 1'b0;
        ifc.corr_power = 16'd0;

        for (int t = 1; t <= end_t; t++) begin
            @(posedge clk); #1;
            ifc.start = (t == restart_at);
            ifc.abort = (t == abort_at);
            ifc.dop_center = 12'($urandom);
            ifc.threshold  = 16'($urandom);
            bb = (t - 1) / BT;
            pp = (t - 1) % BT;
            if (bb < NB) begin
                ifc.corr_valid = vl[bb][pp];
                ifc.corr_power = pw[bb][pp];
            end else begin
                ifc.corr_valid = 1'b0;
                ifc.corr_power = 16'd0;
            end
            @(negedge clk);
            bx = (bb < hold_bin) ? bb : hold_bin;
            chk({tag, "_busy"},   32'(ifc.busy),   32'(t <= last_busy));
            chk({tag, "_done"},   32'(ifc.done),   32'(t == done_t));
            chk({tag, "_satset"}, 32'(ifc.satset), 32'(bx / B));
            chk({tag, "_dopset"}, 32'(ifc.dopset), 32'(ref_dop(center, bx % B)));
            if (t == 1) begin
                chk({tag, "_clr_found"}, 32'(ifc.found),      32'd0);
                chk({tag, "_clr_best"},  32'(ifc.best_power), 32'd0);
                chk({tag, "_clr_fprn"},  32'(ifc.found_prn),  32'd0);
                chk({tag, "_clr_fdop"},  32'(ifc.found_dop),  32'd0);
            end
        end
        ifc.corr_valid = 1'b0;
        chk({tag, "_found"},     32'(ifc.found),      32'(efound));
        chk({tag, "_found_prn"}, 32'(ifc.found_prn),  32'(eprn));
        chk({tag, "_found_dop"}, 32'(ifc.found_dop),  32'(edop));
        chk({tag, "_best"},      32'(ifc.best_power), 32'(ebest));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ifc.start = 1'b0;
        ifc.abort = 1'b0;
        ifc.dop_center = 12'd0;
        ifc.threshold = 16'd0;
        ifc.corr_valid = 1'b0;
        ifc.corr_power = 16'd0;

        // Power-on reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Detection at PRN2/k2 after 9 bins.
        fill(0);
        run_sweep("detect", 12'd100, 16'd500, 0, 0);

        // Dopset wrap, full exhaustion, best bin PRN3/k2.
        fill(1);
        run_sweep("exhaust", 12'd2, 16'hFFFF, 0, 0);

        // Power only while settling must be ignored.
        fill(2);
        run_sweep("settle_only", 12'd100, 16'd500, 0, 0);

        // Abort in bin 1.
        fill(3);
        run_sweep("abort", 12'd50, 16'hFFFF, 15, 0);

        // start+abort together in IDLE: stays idle, config holds.
        @(posedge clk); #1;
        ifc.start = 1'b1;
        ifc.abort = 1'b1;
        @(posedge clk); #1;
        ifc.start = 1'b0;
        ifc.abort = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("idle_sa_busy",   32'(ifc.busy),   32'd0);
            chk("idle_sa_done",   32'(ifc.done),   32'd0);
            chk("idle_sa_satset", 32'(ifc.satset), 32'd0);
            chk("idle_sa_dopset", 32'(ifc.dopset), 32'(ref_dop(12'd50, 1)));
            @(posedge clk); #1;
        end

        // start while busy is ignored.
        fill(0);
        run_sweep("restart", 12'd100, 16'd500, 0, 20);

        // Zero threshold detects on the first bin.
        fill(3);
        run_sweep("thr0", 12'd4000, 16'd0, 0, 0);

        // Randomized sweeps.
        repeat (6) begin
            fill(3);
            run_sweep("rand", 12'($urandom), 16'($urandom_range(700, 1000)), 0, 0);
        end

        // Reset mid-sweep (after bin 1 has produced a nonzero best).
        fill(1);
        @(posedge clk); #1;
        ifc.start = 1'b1;
        ifc.dop_center = 12'd300;
        ifc.threshold = 16'hFFFF;
        @(posedge clk); #1;
        ifc.start = 1'b0;
        ifc.corr_valid = 1'b1;
        ifc.corr_power = 16'd77;
        repeat (25) @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("midreset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        ifc.corr_valid = 1'b0;

        // Normal operation after reset.
        fill(0);
        run_sweep("post_reset", 12'd100, 16'd500, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
